// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Memory-side responder for the MEM-stage data port. Accepts a word-aligned
//   request with per-byte write enables. Services it against an internal
//   word-organised RAM after WAIT_CYCLES wait states, and returns registered
//   read data. Holds the pipeline with ram_stall until the access completes.
//   Accesses outside the implemented range raise a one-cycle ram_error.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   ram_en         in   access request from the MEM stage
//   ram_write_en   in   [3:0] byte-lane write enables, 0000 = read
//   ram_addr       in   [31:0] byte address, bits 1:0 ignored
//   ram_write_data in   [31:0] lane-aligned write data
//   ram_read_data  out  [31:0] registered read word
//   ram_stall      out  stall request while an access is in flight
//   ram_error      out  one-cycle out-of-range indication (DONE cycle)

module data_ram_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_read_data,
    output logic        ram_stall,
    output logic        ram_error
);

    localparam int unsigned Words   = 2 ** ADDR_W;
    localparam logic [3:0]  CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] req_addr_q;
    logic [3:0]  req_we_q;
    logic [31:0] req_wdata_q;

    logic [31:0] mem [Words];

    // Request that completes on this edge: live inputs when finishing straight
    // from IDLE (no wait states), otherwise the captured request.
    logic [31:0]       acc_addr;
    logic [3:0]        acc_we;
    logic [31:0]       acc_wdata;
    logic              go_done;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              unused_addr_lsbs;

    always_comb begin
        acc_addr  = req_addr_q;
        acc_we    = req_we_q;
        acc_wdata = req_wdata_q;
        if (state_q == StIdle) begin
            acc_addr  = ram_addr;
            acc_we    = ram_write_en;
            acc_wdata = ram_write_data;
        end
    end

    always_comb begin
        go_done = 1'b0;
        unique case (state_q)
            StIdle:  go_done = ram_en && (WAIT_CYCLES == 0);
            StWait:  go_done = ram_en && (cnt_q == 4'd0);
            default: go_done = 1'b0;
        endcase
    end

    assign in_range         = (acc_addr >> (ADDR_W + 2)) == 32'd0;
    assign idx              = acc_addr[ADDR_W+1:2];
    assign unused_addr_lsbs = ^acc_addr[1:0];

    assign ram_stall = ram_en && ((state_q == StIdle) || (state_q == StWait));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            req_addr_q    <= 32'd0;
            req_we_q      <= 4'd0;
            req_wdata_q   <= 32'd0;
            ram_read_data <= 32'd0;
            ram_error     <= 1'b0;
        end else begin
            ram_error <= go_done && !in_range;
            if (go_done && (acc_we == 4'd0)) begin
                ram_read_data <= in_range ? mem[idx] : 32'd0;
            end
            unique case (state_q)
                StIdle: begin
                    if (ram_en) begin
                        req_addr_q  <= ram_addr;
                        req_we_q    <= ram_write_en;
                        req_wdata_q <= ram_write_data;
                        cnt_q       <= CntInit;
                        state_q     <= (WAIT_CYCLES > 0) ? StWait : StDone;
                    end
                end
                StWait: begin
                    if (!ram_en) begin
                        // Pipeline flush: drop the request without touching the RAM.
                        state_q <= StIdle;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM array has no reset; only the enabled lanes are written.
    always_ff @(posedge clk) begin
        if (go_done && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_we[i]) begin
                    mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;

    logic [31:0] rd2, rd0;
    logic        stall2, stall0, err2, err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Two instances share the inputs: default wait states and zero wait states.
    data_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (rd2),
        .ram_stall      (stall2),
        .ram_error      (err2)
    );

    data_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (rd0),
        .ram_stall      (stall0),
        .ram_error      (err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full access on dut2 (WAIT_CYCLES=2). Entered just after a rising edge with
    // dut2 idle; returns just after a rising edge with dut2 idle again.
    task automatic acc2(input string tag, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err);
        ram_en         = 1'b1;
        ram_write_en   = we;
        ram_addr       = addr;
        ram_write_data = wd;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk({tag, " stall"}, {31'd0, stall2}, 32'd1);
            @(posedge clk); #1;
        end
        // DONE cycle, request still held by the pipeline.
        @(negedge clk);
        chk({tag, " done stall"}, {31'd0, stall2}, 32'd0);
        chk({tag, " done err"}, {31'd0, err2}, {31'd0, exp_err});
        chk({tag, " done rdata"}, rd2, exp_rd);
        @(posedge clk); #1;
        ram_en = 1'b0;
        @(negedge clk);
        chk({tag, " after err"}, {31'd0, err2}, 32'd0);
        chk({tag, " after stall"}, {31'd0, stall2}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        ram_en         = 1'b0;
        ram_write_en   = 4'd0;
        ram_addr       = 32'd0;
        ram_write_data = 32'd0;
        #12;
        chk("reset rdata", rd2, 32'd0);
        chk("reset err", {31'd0, err2}, 32'd0);
        chk("reset stall", {31'd0, stall2}, 32'd0);
        chk("reset rdata w0", rd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word write then read; read data stays 0 across the write.
        acc2("wr 10", 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        acc2("rd 10", 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte lane 1 only.
        acc2("wr lane1", 4'b0010, 32'h10, 32'h0000AA00, 32'hDEADBEEF, 1'b0);
        acc2("rd lane1", 4'b0000, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);

        // Out of range: write dropped, read returns 0, no aliasing.
        acc2("oor wr", 4'b1111, 32'h80000010, 32'h12345678, 32'hDEADAAEF, 1'b1);
        acc2("oor rd", 4'b0000, 32'h80000010, 32'h0, 32'h0, 1'b1);
        acc2("alias rd", 4'b0000, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);

        // Abort in the first WAIT cycle.
        acc2("pre 20", 4'b1111, 32'h20, 32'hCAFEF00D, 32'hDEADAAEF, 1'b0);
        ram_en         = 1'b1;
        ram_write_en   = 4'b1111;
        ram_addr       = 32'h20;
        ram_write_data = 32'h11223344;
        @(negedge clk);
        chk("abort accept stall", {31'd0, stall2}, 32'd1);
        @(posedge clk); #1;
        ram_en = 1'b0;
        @(negedge clk);
        chk("abort stall", {31'd0, stall2}, 32'd0);
        chk("abort err", {31'd0, err2}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort idle err", {31'd0, err2}, 32'd0);
        @(posedge clk); #1;
        acc2("abort rd", 4'b0000, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

        // Reset mid-access.
        acc2("pre 40", 4'b1111, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
        ram_en         = 1'b1;
        ram_write_en   = 4'b1111;
        ram_addr       = 32'h40;
        ram_write_data = 32'h55555555;
        @(posedge clk); #2;
        rst_n  = 1'b0;
        ram_en = 1'b0;
        #1;
        chk("mid rst rdata", rd2, 32'd0);
        chk("mid rst err", {31'd0, err2}, 32'd0);
        chk("mid rst stall", {31'd0, stall2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        acc2("rst rd 40", 4'b0000, 32'h40, 32'h0, 32'h0, 1'b0);

        // Zero wait states, back-to-back on dut0.
        ram_en         = 1'b1;
        ram_write_en   = 4'b1111;
        ram_addr       = 32'h3FC;
        ram_write_data = 32'hA5A5A5A5;
        @(negedge clk);
        chk("w0 wr stall", {31'd0, stall0}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w0 wr done stall", {31'd0, stall0}, 32'd0);
        chk("w0 wr done err", {31'd0, err0}, 32'd0);
        @(posedge clk); #1;
        ram_write_en   = 4'b0000;
        ram_write_data = 32'h0;
        @(negedge clk);
        chk("w0 rd stall", {31'd0, stall0}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w0 rd done stall", {31'd0, stall0}, 32'd0);
        chk("w0 rd data", rd0, 32'hA5A5A5A5);
        @(posedge clk); #1;
        ram_en = 1'b0;
        @(negedge clk);
        chk("w0 idle stall", {31'd0, stall0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Memory-side responder for the data-memory port driven by the MEM pipeline stage. Accepts word-aligned requests with per-byte write enables, services them against an internal word-organised RAM with a configurable number of wait states, and returns read data. Holds the pipeline with a stall request until each access completes. Flags accesses that fall outside the implemented address range.

## Interface
- `ADDR_W`, 10: word-index bits. The RAM holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 2: extra wait states per access. Legal range 0..15.

- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ram_en`  in  1  access request, driven by the MEM stage.
- `ram_write_en`  in  4  byte write enables. Bit i writes byte lane i (bits 8i+7:8i). 0000 means a read.
- `ram_addr`  in  32  byte address. Bits 1:0 are always 00 from the MEM stage and are ignored here.
- `ram_write_data`  in  32  write data, already lane-shifted by the MEM stage.
- `ram_read_data`  out  32  full read word, registered. The MEM/WB path does byte/half selection and extension.
- `ram_stall`  out  1  stall request to pipeline control. While high, the MEM stage holds its request.
- `ram_error`  out  1  out-of-range access indication. Pulses for one cycle.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE
  - If `ram_en`=0: stay in IDLE.
  - If `ram_en`=1: capture `ram_addr`, `ram_write_en` and `ram_write_data` into request registers.
  - Next state is WAIT if WAIT_CYCLES>0, else DONE. The wait counter loads WAIT_CYCLES-1.
- WAIT
  - If `ram_en`=1: the counter decrements each cycle. When the counter is 0, go to DONE.
  - If `ram_en`=0 (pipeline flush): abort. Return to IDLE with no memory write and no `ram_error`.
  - Input changes other than `ram_en` are ignored; the captured request is used.
- DONE: the access is performed on the edge that enters DONE. DONE lasts exactly one cycle, then returns to IDLE unconditionally.
  - Any `ram_en` seen during DONE belongs to the completed request and is not re-accepted.
- Range check: in range iff `ram_addr[31:ADDR_W+2]` == 0. Word index is `ram_addr[ADDR_W+1:2]`.
- In-range write: only the enabled byte lanes of the indexed word are updated. Other lanes are unchanged. `ram_read_data` is unchanged.
- In-range read: `ram_read_data` is loaded with the indexed word.
- Out-of-range write: dropped. There is no aliasing into the array.
- Out-of-range read: `ram_read_data` is loaded with 0.
- `ram_error` is 1 during the DONE cycle of any out-of-range access, otherwise 0.
- The RAM array is not cleared by reset. Contents are undefined until written.

## Timing
- `ram_stall` is combinational: (IDLE && `ram_en`) || (WAIT && `ram_en`). It is 0 in DONE.
- A request first seen in cycle 0 stalls for 1+WAIT_CYCLES cycles (cycles 0..WAIT_CYCLES).
  - DONE is cycle WAIT_CYCLES+1, with `ram_stall`=0. The pipeline advances at the end of that cycle.
- Read data is valid from the DONE cycle onward. It is held until the next completed read.
- The earliest new acceptance is the cycle after DONE. Back-to-back accesses cost 2+WAIT_CYCLES cycles each.
- A write followed by a read of the same word returns the newly written data. There is no hazard, because the write commits on entry to DONE.
- Abort: if `ram_en` drops in a WAIT cycle, `ram_stall` is 0 in that same cycle. The state is IDLE next cycle.
- Reset values: `ram_read_data`=0, `ram_error`=0, state IDLE, counter 0. With `ram_en`=0, `ram_stall`=0.
- `rst_n` asserted mid-access clears the outputs, state and counter immediately (asynchronously). The pending write is never committed.
- Reset deassertion is synchronised externally. No request is accepted in the first edge after release if `ram_en`=0.

## Test plan
- **Word write then read.** WAIT_CYCLES=2, after reset.
  - Write 0xDEADBEEF to 0x10 with `ram_write_en`=1111: `ram_stall`=1 for 3 cycles, then DONE with `ram_stall`=0.
  - Read 0x10: `ram_read_data`=0xDEADBEEF in its DONE cycle.
- **Byte-lane write.** Then write `ram_write_en`=0010 with data 0x0000AA00 to 0x10, and read 0x10: returns 0xDEADAAEF.
- **Out of range.**
  - Write 0x12345678 to 0x80000010: `ram_error`=1 in DONE only.
  - Read 0x80000010: `ram_read_data`=0, `ram_error`=1.
  - Read 0x10: still 0xDEADAAEF (no aliasing).
- **Abort.**
  - Start a write of 0x11223344 to 0x20 (0x20 pre-loaded with 0xCAFEF00D). Drop `ram_en` in the first WAIT cycle: `ram_stall`=0 in that cycle, no `ram_error`.
  - Read 0x20: returns 0xCAFEF00D.
- **Back-to-back, WAIT_CYCLES=0.** Write 0xA5A5A5A5 to 0x3FC, then immediately read 0x3FC.
  - Each access stalls exactly 1 cycle and completes in 2.
  - The read returns 0xA5A5A5A5.
- **Reset mid-access.** With WAIT_CYCLES=2, pulse `rst_n` low during WAIT of a write of 0x55555555 to 0x40 (pre-loaded 0x0).
  - Outputs are 0 immediately, state is IDLE.
  - A later read of 0x40 returns 0x0.
